multi_player_engine: RTL and testbench
======================================

MULTI_PLAYER_ENGINE -- requirements
Module: multi_player_engine

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of players (legal 1..4).
REQ-002 SHALL have parameter X_W, default 8, x coordinate width.
REQ-003 SHALL have parameter Y_W, default 7, y coordinate width.
REQ-004 SHALL have parameter X_MAX, default 159, last legal x coordinate.
REQ-005 SHALL have parameter Y_MAX, default 119, last legal y coordinate.
REQ-006 SHALL have parameter TICK_CYCLES, default 1000000, clocks per move tick (minimum 16).
REQ-007 SHALL have parameter WRAP, default 0, edge mode (0 = clamp at wall, 1 = wrap to opposite edge).
REQ-008 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-009 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-010 SHALL have port keycode, input, 8, PS/2 scan code.
REQ-011 SHALL have port key_valid, input, 1, one-cycle strobe qualifying keycode, key_make and key_ext.
REQ-012 SHALL have port key_make, input, 1, 1 = make (press), 0 = break (release).
REQ-013 SHALL have port key_ext, input, 1, E0-extended code flag.
REQ-014 SHALL have port trail, input, 1, 1 = leave trail (erase plot suppressed).
REQ-015 SHALL have port obs_mem, input, 3, obstacle-memory read data (one-cycle latency; nonzero = blocked).
REQ-016 SHALL have port obs_x, output, X_W, obstacle-memory read x address.
REQ-017 SHALL have port obs_y, output, Y_W, obstacle-memory read y address.
REQ-018 SHALL have port x, output, X_W, plot x coordinate.
REQ-019 SHALL have port y, output, Y_W, plot y coordinate.
REQ-020 SHALL have port color_draw, output, 3, plot colour.
REQ-021 SHALL have port plot, output, 1, one-cycle write strobe; x, y and color_draw valid in the same cycle.
REQ-022 SHALL have port state, output, 3, current FSM state encoding.
REQ-023 SHALL have port cur_player, output, 2, index of the player being processed.
REQ-024 SHALL have port move, output, 3, latched direction of cur_player.

Function
REQ-025 SHALL decode directions as 0 none, 1 up, 2 down, 3 left, 4 right, with key sets: p0 E0+75/72/6B/74; p1 1D/1B/1C/23 (WASD); p2 43/42/3B/4B (IJKL); p3 non-ext 75/72/6B/74; ext flag must match.
REQ-026 SHALL latch a player's direction on a make and clear it to none on a break of that same key; a break of a different key leaves the direction unchanged; a key event in the same cycle as LOOKUP for that player takes effect at the next tick.
REQ-027 SHALL run a free counter 0..TICK_CYCLES-1 and set tick_pending at wrap; tick_pending clears on IDLE->LOOKUP; ticks arriving outside IDLE collapse into a single pending tick.
REQ-028 SHALL use FSM states INIT(0), IDLE(1), LOOKUP(2), CHECK(3), ERASE(4), DRAW(5).
REQ-029 SHALL, in INIT, plot each player once at its start position (x = (p+1)*X_MAX/(NUM_PLAYERS+1), y = Y_MAX/2, player colour), one player per cycle, then go to IDLE.
REQ-030 SHALL in LOOKUP for player p: if direction is none, advance to p+1 (or IDLE after the last player); otherwise drive candidate = position + step onto obs_x/obs_y and go to CHECK.
REQ-031 SHALL handle edges as follows: with WRAP=0, a step past 0 or past X_MAX/Y_MAX is blocked; with WRAP=1, left from x=0 gives X_MAX, right from X_MAX gives 0, and y wraps likewise.
REQ-032 SHALL in CHECK treat the move as blocked if obs_mem != 0 or candidate equals any other player's current position; a blocked move plots nothing and advances to the next player.
REQ-033 SHALL in ERASE plot the old position in colour 0, except that when trail=1 no plot is issued (1 cycle either way); DRAW SHALL plot the candidate in the player colour and commit the position.
REQ-034 SHALL produce a first plot 3 cycles after IDLE->LOOKUP for a moving p0; an unblocked move takes 4 cycles, a blocked move 2, and an idle player 1.

Reset
REQ-035 SHALL, on reset, set state=INIT, cur_player=0, all directions none, tick counter 0, tick_pending 0, positions to start values, and plot, x, y, color_draw, obs_x, obs_y, move to 0.
REQ-036 SHALL abandon any in-progress sequence when reset is asserted mid-operation; no plot is issued in the reset cycle.

Structure
REQ-037 SHALL place the direction encodings, state encodings, player colours (p0 010, p1 001, p2 100, p3 110) and key-code table in shared package game_pkg.
REQ-038 SHALL implement key decoding in one sub-module, key_dir_decoder (keycode/ext -> player index, direction, hit).

Verification
REQ-039 SHALL be verified with NUM_PLAYERS=2 and TICK_CYCLES=16: after reset, exactly 2 INIT plots, p0 at (53,59) colour 010 and p1 at (106,59) colour 001.
REQ-040 SHALL be verified as follows: p0 E0 74 make, tick, obs_mem=0 -> plot (53,59) colour 000, then plot (54,59) colour 010.
REQ-041 SHALL be verified as follows: WRAP=0, p1 at x=159 holding 23 (right) -> no plots, position unchanged; WRAP=1 -> plot (0,59) colour 001.
REQ-042 SHALL be verified as follows: obs_mem=3 at the candidate -> no plot; with trail=1 an unblocked move -> only the DRAW plot.
REQ-043 SHALL be verified as follows: break of 1C while 23 is held -> p1 direction stays right; reset asserted in ERASE -> state=INIT next cycle, plot=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the multi-player movement engine: directions,
// FSM states, player colours and the PS/2 key-code table.
package game_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_CHECK  = 3'd3,
    ST_ERASE  = 3'd4,
    ST_DRAW   = 3'd5
  } state_t;

  // Index is the player number: p0 green, p1 blue, p2 red, p3 yellow.
  localparam logic [3:0][2:0] PLAYER_COLOR = {3'b110, 3'b100, 3'b001, 3'b010};

  // KEY_TABLE[player][dir-1], byte order per player is {right, left, down, up}.
  // p0 and p3 share codes and are told apart only by the E0 flag.
  localparam logic [3:0][3:0][7:0] KEY_TABLE = {
    32'h746B7275,   // p3: plain arrow-pad codes
    32'h4B3B4243,   // p2: I K J L
    32'h231C1B1D,   // p1: W S A D
    32'h746B7275    // p0: E0-extended arrows
  };

  localparam logic [3:0] KEY_EXT = 4'b0001;

  function automatic logic [2:0] playerColor(input logic [1:0] p);
    return PLAYER_COLOR[p];
  endfunction

endpackage

// File: rtl/key_dir_decoder.sv
// Maps a PS/2 scan code plus its E0 flag onto (player, direction).
// o_hit is low for any code that belongs to no player's key set.
module key_dir_decoder
  import game_pkg::*;
(
  input  logic [7:0] i_keycode,
  input  logic       i_ext,
  output logic [1:0] o_player,
  output dir_t       o_dir,
  output logic       o_hit
);

  // Search the whole table; every (code, ext) pair appears at most once.
  always_comb begin
    o_player = 2'd0;
    o_dir    = DIR_NONE;
    o_hit    = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int d = 0; d < 4; d++) begin
        if (i_keycode == KEY_TABLE[p][d] && i_ext == KEY_EXT[p]) begin
          o_player = 2'(p);
          o_dir    = dir_t'(3'(d + 1));
          o_hit    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_player_engine.sv
// Tick-driven movement engine for up to four keyboard-controlled players.
// Each tick walks the players in order: look up the step, check the
// obstacle memory and the other players, then erase and redraw.
module multi_player_engine
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int TICK_CYCLES = 1000000,
  parameter int WRAP        = 0
)(
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     keycode,
  input  logic           key_valid,
  input  logic           key_make,
  input  logic           key_ext,
  input  logic           trail,
  input  logic [2:0]     obs_mem,
  output logic [X_W-1:0] obs_x,
  output logic [Y_W-1:0] obs_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     color_draw,
  output logic           plot,
  output logic [2:0]     state,
  output logic [1:0]     cur_player,
  output logic [2:0]     move
);

  localparam int         CNT_W       = $clog2(TICK_CYCLES);
  localparam logic [1:0] LAST_PLAYER = 2'(NUM_PLAYERS - 1);

  function automatic logic [X_W-1:0] startX(input logic [1:0] p);
    return X_W'((int'(p) + 1) * X_MAX / (NUM_PLAYERS + 1));
  endfunction

  function automatic logic [Y_W-1:0] startY();
    return Y_W'(Y_MAX / 2);
  endfunction

  state_t           r_state, w_nextState;
  logic [1:0]       r_cur, w_curNext;
  dir_t             r_dir  [4];
  logic [X_W-1:0]   r_posX [4];
  logic [Y_W-1:0]   r_posY [4];
  logic [X_W-1:0]   r_candX, r_obsX, r_x, w_candX, w_plotX;
  logic [Y_W-1:0]   r_candY, r_obsY, r_y, w_candY, w_plotY;
  logic             r_edgeBlk, w_edgeBlk, w_collide;
  logic [CNT_W-1:0] r_tickCnt;
  logic             r_tickPend, w_tickWrap;
  logic             r_plot, w_plot;
  logic [2:0]       r_color, w_plotColor, r_move;
  logic             w_clrPend, w_latchCand, w_commit, w_advance;
  logic [1:0]       w_keyPlayer;
  dir_t             w_keyDir;
  logic             w_keyHit;

  key_dir_decoder u_keyDec (
    .i_keycode (keycode),
    .i_ext     (key_ext),
    .o_player  (w_keyPlayer),
    .o_dir     (w_keyDir),
    .o_hit     (w_keyHit)
  );

  assign w_tickWrap = (r_tickCnt == CNT_W'(TICK_CYCLES - 1));

  // The obstacle RAM needs the candidate address during LOOKUP so its
  // registered data lines up with CHECK; otherwise hold the last request.
  assign obs_x      = (r_state == ST_LOOKUP) ? w_candX : r_obsX;
  assign obs_y      = (r_state == ST_LOOKUP) ? w_candY : r_obsY;
  assign x          = r_x;
  assign y          = r_y;
  assign color_draw = r_color;
  assign plot       = r_plot;
  assign state      = r_state;
  assign cur_player = r_cur;
  assign move       = r_move;

  // Candidate position one step away, with wall clamping or wrapping.
  always_comb begin
    w_candX   = r_posX[r_cur];
    w_candY   = r_posY[r_cur];
    w_edgeBlk = 1'b0;
    case (r_dir[r_cur])
      DIR_UP: begin
        if (r_posY[r_cur] == '0) begin
          if (WRAP != 0) w_candY = Y_W'(Y_MAX);
          else           w_edgeBlk = 1'b1;
        end else         w_candY = r_posY[r_cur] - Y_W'(1);
      end
      DIR_DOWN: begin
        if (r_posY[r_cur] == Y_W'(Y_MAX)) begin
          if (WRAP != 0) w_candY = '0;
          else           w_edgeBlk = 1'b1;
        end else         w_candY = r_posY[r_cur] + Y_W'(1);
      end
      DIR_LEFT: begin
        if (r_posX[r_cur] == '0) begin
          if (WRAP != 0) w_candX = X_W'(X_MAX);
          else           w_edgeBlk = 1'b1;
        end else         w_candX = r_posX[r_cur] - X_W'(1);
      end
      DIR_RIGHT: begin
        if (r_posX[r_cur] == X_W'(X_MAX)) begin
          if (WRAP != 0) w_candX = '0;
          else           w_edgeBlk = 1'b1;
        end else         w_candX = r_posX[r_cur] + X_W'(1);
      end
      default: ;
    endcase
  end

  // A move into any other active player's current square is refused.
  always_comb begin
    w_collide = 1'b0;
    for (int q = 0; q < 4; q++) begin
      if (q < NUM_PLAYERS && 2'(q) != r_cur &&
          r_candX == r_posX[q] && r_candY == r_posY[q])
        w_collide = 1'b1;
    end
  end

  // Next-state, player sequencing and the plot request for this cycle.
  always_comb begin
    w_nextState = r_state;
    w_curNext   = r_cur;
    w_plot      = 1'b0;
    w_plotX     = r_posX[r_cur];
    w_plotY     = r_posY[r_cur];
    w_plotColor = 3'b000;
    w_clrPend   = 1'b0;
    w_latchCand = 1'b0;
    w_commit    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_plot      = 1'b1;
        w_plotX     = startX(r_cur);
        w_plotY     = startY();
        w_plotColor = playerColor(r_cur);
        if (r_cur == LAST_PLAYER) begin
          w_nextState = ST_IDLE;
          w_curNext   = 2'd0;
        end else begin
          w_curNext   = r_cur + 2'd1;
        end
      end
      ST_IDLE: begin
        if (r_tickPend) begin
          w_nextState = ST_LOOKUP;
          w_clrPend   = 1'b1;
        end
      end
      ST_LOOKUP: begin
        if (r_dir[r_cur] == DIR_NONE) begin
          w_advance = 1'b1;
        end else begin
          w_latchCand = 1'b1;
          w_nextState = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (obs_mem != 3'd0 || r_edgeBlk || w_collide) w_advance = 1'b1;
        else                                            w_nextState = ST_ERASE;
      end
      ST_ERASE: begin
        w_plot      = !trail;
        w_nextState = ST_DRAW;
      end
      ST_DRAW: begin
        w_plot      = 1'b1;
        w_plotX     = r_candX;
        w_plotY     = r_candY;
        w_plotColor = playerColor(r_cur);
        w_commit    = 1'b1;
        w_advance   = 1'b1;
      end
      default: begin
        w_nextState = ST_INIT;
        w_curNext   = 2'd0;
      end
    endcase
    if (w_advance) begin
      if (r_cur == LAST_PLAYER) begin
        w_nextState = ST_IDLE;
        w_curNext   = 2'd0;
      end else begin
        w_nextState = ST_LOOKUP;
        w_curNext   = r_cur + 2'd1;
      end
    end
  end

  // State register, candidate latch and registered plot outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_cur     <= 2'd0;
      r_candX   <= '0;
      r_candY   <= '0;
      r_edgeBlk <= 1'b0;
      r_obsX    <= '0;
      r_obsY    <= '0;
      r_move    <= 3'd0;
      r_plot    <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_color   <= 3'd0;
    end else begin
      r_state <= w_nextState;
      r_cur   <= w_curNext;
      r_plot  <= w_plot;
      r_x     <= w_plotX;
      r_y     <= w_plotY;
      r_color <= w_plotColor;
      if (r_state == ST_LOOKUP) r_move <= r_dir[r_cur];
      if (w_latchCand) begin
        r_candX   <= w_candX;
        r_candY   <= w_candY;
        r_edgeBlk <= w_edgeBlk;
        r_obsX    <= w_candX;
        r_obsY    <= w_candY;
      end
    end
  end

  // Player positions and key-driven directions; a break only clears the
  // direction it set, so releasing some other key of the same set is harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        r_posX[p] <= startX(2'(p));
        r_posY[p] <= startY();
        r_dir[p]  <= DIR_NONE;
      end
    end else begin
      if (w_commit) begin
        r_posX[r_cur] <= r_candX;
        r_posY[r_cur] <= r_candY;
      end
      if (key_valid && w_keyHit && int'(w_keyPlayer) < NUM_PLAYERS) begin
        if (key_make)                          r_dir[w_keyPlayer] <= w_keyDir;
        else if (r_dir[w_keyPlayer] == w_keyDir) r_dir[w_keyPlayer] <= DIR_NONE;
      end
    end
  end

  // Free-running tick divider; ticks that land while busy merge into one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tickCnt  <= '0;
      r_tickPend <= 1'b0;
    end else begin
      r_tickCnt <= w_tickWrap ? '0 : r_tickCnt + CNT_W'(1);
      if (w_tickWrap)     r_tickPend <= 1'b1;
      else if (w_clrPend) r_tickPend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_player_engine.sv
// Directed bench: a clamping and a wrapping engine share all stimulus;
// each has a small obstacle RAM model and a plot recorder.
module tb_multi_player_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] keycode = 8'd0;
  logic       key_valid = 1'b0, key_make = 1'b0, key_ext = 1'b0, trail = 1'b0;
  logic [7:0] blkX = 8'd255;
  logic [6:0] blkY = 7'd127;

  logic [2:0] obsMemC = 3'd0, obsMemW = 3'd0;
  logic [7:0] obsXC, obsXW, xC, xW;
  logic [6:0] obsYC, obsYW, yC, yW;
  logic [2:0] colorC, colorW, stateC, stateW, moveC, moveW;
  logic       plotC, plotW;
  logic [1:0] curC, curW;

  int compared = 0;
  int mismatched = 0;
  int cycleCount = 0;
  int lastLookup = 0;
  logic [2:0] prevStateC = 3'd0;
  logic [17:0] qC[$];
  logic [17:0] qW[$];
  int qLat[$];

  multi_player_engine #(.NUM_PLAYERS(2), .TICK_CYCLES(16), .WRAP(0)) dutClamp (
    .clk(clk), .reset(reset), .keycode(keycode), .key_valid(key_valid),
    .key_make(key_make), .key_ext(key_ext), .trail(trail), .obs_mem(obsMemC),
    .obs_x(obsXC), .obs_y(obsYC), .x(xC), .y(yC), .color_draw(colorC),
    .plot(plotC), .state(stateC), .cur_player(curC), .move(moveC)
  );

  multi_player_engine #(.NUM_PLAYERS(2), .TICK_CYCLES(16), .WRAP(1)) dutWrap (
    .clk(clk), .reset(reset), .keycode(keycode), .key_valid(key_valid),
    .key_make(key_make), .key_ext(key_ext), .trail(trail), .obs_mem(obsMemW),
    .obs_x(obsXW), .obs_y(obsYW), .x(xW), .y(yW), .color_draw(colorW),
    .plot(plotW), .state(stateW), .cur_player(curW), .move(moveW)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time plots against the start of a move tick.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Obstacle RAMs with one cycle of read latency; only (blkX,blkY) is blocked.
  always @(posedge clk) begin
    obsMemC <= (obsXC == blkX && obsYC == blkY) ? 3'd3 : 3'd0;
    obsMemW <= (obsXW == blkX && obsYW == blkY) ? 3'd3 : 3'd0;
  end

  // Plot recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (stateC == 3'd2 && prevStateC == 3'd1) lastLookup = cycleCount;
    prevStateC = stateC;
    if (!reset && plotC) begin
      qC.push_back({xC, yC, colorC});
      qLat.push_back(cycleCount - lastLookup);
    end
    if (!reset && plotW) qW.push_back({xW, yW, colorW});
  end

  function automatic logic [17:0] packPlot(input int px, input int py, input int pc);
    return {8'(px), 7'(py), 3'(pc)};
  endfunction

  function automatic logic [17:0] getC(input int i);
    if (i < qC.size()) return qC[i];
    return '1;
  endfunction

  function automatic logic [17:0] getW(input int i);
    if (i < qW.size()) return qW[i];
    return '1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input logic ext, input logic make);
    @(negedge clk);
    keycode   = code;
    key_ext   = ext;
    key_make  = make;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitPlots(input int n, input bit useWrap, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((useWrap ? qW.size() : qC.size()) >= n) break;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clearQueues();
    qC.delete();
    qW.delete();
    qLat.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    waitCycles(3);
    checkOutput("rst_state", 32'(stateC), 32'd0);
    checkOutput("rst_plot",  32'(plotC),  32'd0);
    checkOutput("rst_cur",   32'(curC),   32'd0);
    checkOutput("rst_move",  32'(moveC),  32'd0);
    checkOutput("rst_x",     32'(xC),     32'd0);
    checkOutput("rst_y",     32'(yC),     32'd0);
    checkOutput("rst_color", 32'(colorC), 32'd0);
    checkOutput("rst_obs_x", 32'(obsXC),  32'd0);

    @(negedge clk);
    reset = 1'b0;
    waitPlots(2, 1'b0, 20);
    waitCycles(1);
    checkOutput("init_count", 32'(qC.size()), 32'd2);
    checkOutput("init_p0", 32'(getC(0)), 32'(packPlot(53, 59, 2)));
    checkOutput("init_p1", 32'(getC(1)), 32'(packPlot(106, 59, 1)));
    checkOutput("init_wrap_count", 32'(qW.size()), 32'd2);
    checkOutput("idle_state", 32'(stateC), 32'd1);

    // p0 moves right once
    clearQueues();
    applyStimulus(8'h74, 1'b1, 1'b1);
    waitPlots(2, 1'b0, 40);
    applyStimulus(8'h74, 1'b1, 1'b0);
    waitCycles(20);
    checkOutput("mv_count", 32'(qC.size()), 32'd2);
    checkOutput("mv_erase", 32'(getC(0)), 32'(packPlot(53, 59, 0)));
    checkOutput("mv_draw",  32'(getC(1)), 32'(packPlot(54, 59, 2)));
    checkOutput("mv_lat_erase", 32'(qLat.size() > 0 ? qLat[0] : -1), 32'd3);
    checkOutput("mv_lat_draw",  32'(qLat.size() > 1 ? qLat[1] : -1), 32'd4);

    // obstacle at (55,59) blocks p0, then trail mode after it is removed
    clearQueues();
    blkX = 8'd55;
    blkY = 7'd59;
    trail = 1'b1;
    applyStimulus(8'h74, 1'b1, 1'b1);
    waitCycles(40);
    checkOutput("blocked_count", 32'(qC.size()), 32'd0);
    blkX = 8'd255;
    blkY = 7'd127;
    waitPlots(1, 1'b0, 40);
    applyStimulus(8'h74, 1'b1, 1'b0);
    waitCycles(20);
    checkOutput("trail_count", 32'(qC.size()), 32'd1);
    checkOutput("trail_draw",  32'(getC(0)), 32'(packPlot(55, 59, 2)));
    trail = 1'b0;

    // p1 holds right to the wall; a stray break of A must not stop it
    clearQueues();
    applyStimulus(8'h23, 1'b0, 1'b1);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    waitPlots(106, 1'b0, 1100);
    checkOutput("run_count", 32'(qC.size()), 32'd106);
    checkOutput("run_first", 32'(getC(0)), 32'(packPlot(106, 59, 0)));
    checkOutput("run_last",  32'(getC(105)), 32'(packPlot(159, 59, 1)));
    checkOutput("run_wrap_count", 32'(qW.size()), 32'd106);

    clearQueues();
    waitPlots(2, 1'b1, 40);
    applyStimulus(8'h23, 1'b0, 1'b0);
    waitCycles(20);
    checkOutput("wall_clamp_count", 32'(qC.size()), 32'd0);
    checkOutput("wall_wrap_count", 32'(qW.size()), 32'd2);
    checkOutput("wall_wrap_erase", 32'(getW(0)), 32'(packPlot(159, 59, 0)));
    checkOutput("wall_wrap_draw",  32'(getW(1)), 32'(packPlot(0, 59, 1)));

    // step back left: clamp engine was still at 159, wrap engine at 0
    clearQueues();
    applyStimulus(8'h1C, 1'b0, 1'b1);
    waitPlots(2, 1'b0, 40);
    waitPlots(2, 1'b1, 10);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    waitCycles(20);
    checkOutput("left_clamp_count", 32'(qC.size()), 32'd2);
    checkOutput("left_clamp_erase", 32'(getC(0)), 32'(packPlot(159, 59, 0)));
    checkOutput("left_clamp_draw",  32'(getC(1)), 32'(packPlot(158, 59, 1)));
    checkOutput("left_wrap_erase",  32'(getW(0)), 32'(packPlot(0, 59, 0)));
    checkOutput("left_wrap_draw",   32'(getW(1)), 32'(packPlot(159, 59, 1)));

    // reset in the middle of a move
    clearQueues();
    applyStimulus(8'h74, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (stateC == 3'd4) break;
      @(posedge clk);
      #2;
    end
    checkOutput("reach_erase", 32'(stateC), 32'd4);
    checkOutput("erase_cur",   32'(curC),   32'd0);
    checkOutput("erase_move",  32'(moveC),  32'd4);
    reset = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("midrst_state", 32'(stateC), 32'd0);
    checkOutput("midrst_plot",  32'(plotC),  32'd0);
    applyStimulus(8'h74, 1'b1, 1'b0);
    clearQueues();
    @(negedge clk);
    reset = 1'b0;
    waitPlots(2, 1'b0, 20);
    checkOutput("reinit_p0", 32'(getC(0)), 32'(packPlot(53, 59, 2)));
    checkOutput("reinit_p1", 32'(getC(1)), 32'(packPlot(106, 59, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
